// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : proc_pkg
//  Brief    : Shared processor constants: MEM stage FSM encodings and the
//             default data-memory geometry / access latency.
//  Revision : 1.0
// ============================================================================
package proc_pkg;

    localparam int c_mem_words_default   = 256;
    localparam int c_mem_latency_default = 3;

    localparam int c_state_w = 1;
    typedef logic [c_state_w-1:0] mem_state_t;

    localparam mem_state_t c_state_idle = 1'b0;
    localparam mem_state_t c_state_wait = 1'b1;

    // Wait counter must hold values 0 .. latency-1; never narrower than 1 bit.
    function automatic int wait_cnt_width(input int latency);
        return (latency > 1) ? $clog2(latency) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem
//  Brief    : Word-addressed data memory, synchronous write and
//             combinational (read-before-write) read.
//  Revision : 1.0
// ============================================================================
module data_mem #(
    parameter int WORDS  = 256,
    parameter int ADDR_W = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    // Contents are deliberately not reset: a processor reset keeps memory.
    logic [31:0] r_mem [WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage
//  Brief    : Pipeline MEM stage with multi-cycle data-memory access,
//             stall generation and the MEM/WB pipeline register.
//  Revision : 1.0
// ============================================================================
module mem_stage
    import proc_pkg::*;
#(
    parameter int MEM_WORDS   = c_mem_words_default,
    parameter int MEM_LATENCY = c_mem_latency_default
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        regWriteM,
    input  logic        memToRegM,
    input  logic        memWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] writeDataM,
    input  logic [4:0]  writeRegM,
    output logic        stallMem,
    output logic        regWriteW,
    output logic        memToRegW,
    output logic [31:0] readDataW,
    output logic [31:0] ALUOutW,
    output logic [4:0]  writeRegW,
    output logic [31:0] resultW
);

    localparam int c_addr_w = $clog2(MEM_WORDS);
    localparam int c_cnt_w  = wait_cnt_width(MEM_LATENCY);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(MEM_LATENCY - 1);

    mem_state_t          r_state;
    mem_state_t          w_state_next;
    logic [c_cnt_w-1:0]  r_wait_cnt;
    logic [c_cnt_w-1:0]  w_wait_cnt_next;
    logic                w_mem_op;
    logic                w_stall;
    logic                w_mem_we;
    logic [c_addr_w-1:0] w_addr;
    logic [31:0]         w_rdata;

    assign w_mem_op = memToRegM | memWriteM;
    // Byte offset and bits above the memory depth are dropped, so addresses wrap.
    assign w_addr   = ALUOutM[c_addr_w+1:2];
    assign w_mem_we = memWriteM & ~w_stall & ~rst;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_state_idle;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    // Next state: count while stalled, fall back to IDLE on the completing edge
    always_comb begin
        w_state_next    = c_state_idle;
        w_wait_cnt_next = '0;
        case (r_state)
            c_state_idle: begin
                if (w_stall) begin
                    w_state_next    = c_state_wait;
                    w_wait_cnt_next = c_cnt_w'(1);
                end
            end
            c_state_wait: begin
                if (w_stall) begin
                    w_state_next    = c_state_wait;
                    w_wait_cnt_next = r_wait_cnt + c_cnt_w'(1);
                end
            end
            default: begin
                w_state_next    = c_state_idle;
                w_wait_cnt_next = '0;
            end
        endcase
    end

    // Output: stall every cycle of a memory op except its last
    always_comb begin
        w_stall = 1'b0;
        if (!rst && w_mem_op) begin
            case (r_state)
                c_state_idle: w_stall = (c_last != '0);
                default:      w_stall = (r_wait_cnt != c_last);
            endcase
        end
    end

    assign stallMem = w_stall;

    data_mem #(
        .WORDS (MEM_WORDS)
    ) u_data_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_addr  (w_addr),
        .i_wdata (writeDataM),
        .o_rdata (w_rdata)
    );

    // MEM/WB register: a stalled cycle inserts a bubble but keeps the data fields
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regWriteW <= 1'b0;
            memToRegW <= 1'b0;
            writeRegW <= '0;
            readDataW <= '0;
            ALUOutW   <= '0;
        end else if (w_stall) begin
            regWriteW <= 1'b0;
            memToRegW <= 1'b0;
        end else begin
            regWriteW <= regWriteM;
            memToRegW <= memToRegM;
            writeRegW <= writeRegM;
            readDataW <= w_rdata;
            ALUOutW   <= ALUOutM;
        end
    end

    assign resultW = memToRegW ? readDataW : ALUOutW;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage
//  Brief    : Self-checking bench for mem_stage against a word-array model.
//  Revision : 1.0
// ============================================================================
module tb_mem_stage;

    localparam int MEM_WORDS = 256;
    localparam int LAT       = 3;
    localparam int AW        = $clog2(MEM_WORDS);

    logic        clk = 1'b0;
    logic        rst;
    logic        regWriteM, memToRegM, memWriteM;
    logic [31:0] ALUOutM, writeDataM;
    logic [4:0]  writeRegM;
    logic        stallMem, regWriteW, memToRegW;
    logic [31:0] readDataW, ALUOutW, resultW;
    logic [4:0]  writeRegW;

    int checks = 0;
    int passed = 0;

    // Reference model: memory words and the MEM/WB contents expected next
    logic [31:0] mdl_mem   [MEM_WORDS];
    bit          mdl_known [MEM_WORDS];
    logic        m_rw, m_mtr;
    logic [4:0]  m_wr;
    logic [31:0] m_alu, m_rd;
    bit          m_rd_valid;

    always #5 clk = ~clk;

    mem_stage #(
        .MEM_WORDS   (MEM_WORDS),
        .MEM_LATENCY (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .regWriteM  (regWriteM),
        .memToRegM  (memToRegM),
        .memWriteM  (memWriteM),
        .ALUOutM    (ALUOutM),
        .writeDataM (writeDataM),
        .writeRegM  (writeRegM),
        .stallMem   (stallMem),
        .regWriteW  (regWriteW),
        .memToRegW  (memToRegW),
        .readDataW  (readDataW),
        .ALUOutW    (ALUOutW),
        .writeRegW  (writeRegW),
        .resultW    (resultW)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] exp_seq(input bit memop);
        return memop ? 8'((1 << (LAT - 1)) - 1) : 8'h00;
    endfunction

    function automatic int exp_cycles(input bit memop);
        return memop ? LAT : 1;
    endfunction

    task automatic model_reset();
        m_rw = 0; m_mtr = 0; m_wr = '0; m_alu = '0; m_rd = '0; m_rd_valid = 1;
    endtask

    // Applied once per completed op: latch fields, read old word, then write
    task automatic model_commit(input logic rw, input logic mtr, input logic mw,
                                input logic [31:0] alu, input logic [31:0] wd,
                                input logic [4:0] wr);
        int idx;
        idx = int'(alu[AW+1:2]);
        m_rw = rw; m_mtr = mtr; m_wr = wr; m_alu = alu;
        m_rd = mdl_mem[idx];
        m_rd_valid = (mtr | mw) && mdl_known[idx];
        if (mw) begin
            mdl_mem[idx]   = wd;
            mdl_known[idx] = 1;
        end
    endtask

    task automatic idle(input int n);
        regWriteM = 0; memToRegM = 0; memWriteM = 0;
        ALUOutM = '0; writeDataM = '0; writeRegM = '0;
        repeat (n) begin
            @(posedge clk); #1;
            model_commit(0, 0, 0, '0, '0, '0);
        end
    endtask

    // Drives one op (called at edge+1) and observes it until it leaves the stage
    task automatic do_op(input logic rw, input logic mtr, input logic mw,
                         input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] wr,
                         output logic [7:0] seq, output int ncyc, output bit bubble_ok);
        regWriteM = rw; memToRegM = mtr; memWriteM = mw;
        ALUOutM = alu; writeDataM = wd; writeRegM = wr;
        seq = '0; ncyc = 0; bubble_ok = 1;
        forever begin
            #1;
            seq[ncyc] = stallMem;
            @(posedge clk); #1;
            ncyc++;
            if (seq[ncyc-1] !== 1'b1) break;
            if (regWriteW !== 1'b0 || memToRegW !== 1'b0 ||
                ALUOutW !== m_alu || writeRegW !== m_wr) bubble_ok = 0;
            if (ncyc >= 8) break;
        end
    endtask

    task automatic test_reset();
        rst = 1;
        regWriteM = 1; memToRegM = 0; memWriteM = 1;
        ALUOutM = 32'h10; writeDataM = 32'h1; writeRegM = 5'd3;
        #3;
        checks++; if (stallMem !== 1'b0) $display("FAIL reset_stall: got %b want 0", stallMem); else passed++;
        checks++;
        if ({regWriteW, memToRegW, writeRegW, readDataW, ALUOutW} !== '0)
            $display("FAIL reset_wb: got rw=%b mtr=%b wr=%0d rd=%h alu=%h want all 0",
                     regWriteW, memToRegW, writeRegW, readDataW, ALUOutW);
        else passed++;
        @(posedge clk); @(posedge clk); #4;
        rst = 0;
        model_reset();
        idle(2);
        checks++; if (regWriteW !== 1'b0) $display("FAIL reset_idle_rw: got %b want 0", regWriteW); else passed++;
    endtask

    task automatic test_alu();
        logic [7:0] seq; int n; bit bok;
        do_op(1, 0, 0, 32'h40, 32'h0BAD_0BAD, 5'd5, seq, n, bok);
        model_commit(1, 0, 0, 32'h40, 32'h0BAD_0BAD, 5'd5);
        checks++; if (seq[0] !== 1'b0 || n != 1) $display("FAIL alu_stall: got seq=%b n=%0d want 0/1", seq, n); else passed++;
        checks++; if (regWriteW !== 1'b1) $display("FAIL alu_rw: got %b want 1", regWriteW); else passed++;
        checks++; if (ALUOutW !== 32'h40) $display("FAIL alu_out: got %h want 40", ALUOutW); else passed++;
        checks++; if (writeRegW !== 5'd5) $display("FAIL alu_wr: got %0d want 5", writeRegW); else passed++;
        checks++; if (resultW !== 32'h40) $display("FAIL alu_result: got %h want 40", resultW); else passed++;
    endtask

    task automatic test_store_load();
        logic [7:0] seq; int n; bit bok;
        do_op(0, 0, 1, 32'h10, 32'hDEAD_BEEF, 5'd2, seq, n, bok);
        model_commit(0, 0, 1, 32'h10, 32'hDEAD_BEEF, 5'd2);
        checks++; if (seq !== 8'b011 || n != 3) $display("FAIL st_stall: got seq=%b n=%0d want 011/3", seq, n); else passed++;
        checks++; if (!bok || regWriteW !== 1'b0) $display("FAIL st_rw: got bubble_ok=%0d rw=%b want 1/0", bok, regWriteW); else passed++;
        do_op(1, 1, 0, 32'h13, 32'h0, 5'd8, seq, n, bok);
        model_commit(1, 1, 0, 32'h13, 32'h0, 5'd8);
        checks++; if (seq !== 8'b011 || n != 3) $display("FAIL ld_stall: got seq=%b n=%0d want 011/3", seq, n); else passed++;
        checks++; if (!bok) $display("FAIL ld_bubble: got bubble_ok=0 want 1"); else passed++;
        checks++; if (readDataW !== 32'hDEAD_BEEF) $display("FAIL ld_data: got %h want deadbeef", readDataW); else passed++;
        checks++; if (resultW !== 32'hDEAD_BEEF) $display("FAIL ld_result: got %h want deadbeef", resultW); else passed++;
        checks++; if (regWriteW !== 1'b1 || writeRegW !== 5'd8) $display("FAIL ld_dest: got rw=%b wr=%0d want 1/8", regWriteW, writeRegW); else passed++;
    endtask

    task automatic test_wrap();
        logic [7:0] seq; int n; bit bok;
        do_op(0, 0, 1, 32'h410, 32'h1234, 5'd0, seq, n, bok);
        model_commit(0, 0, 1, 32'h410, 32'h1234, 5'd0);
        do_op(1, 1, 0, 32'h10, 32'h0, 5'd9, seq, n, bok);
        model_commit(1, 1, 0, 32'h10, 32'h0, 5'd9);
        checks++; if (readDataW !== 32'h1234) $display("FAIL wrap_data: got %h want 1234", readDataW); else passed++;
    endtask

    task automatic test_reset_mid_store();
        logic [7:0] seq; int n; bit bok;
        do_op(0, 0, 1, 32'h20, 32'hCAFE_0020, 5'd0, seq, n, bok);
        model_commit(0, 0, 1, 32'h20, 32'hCAFE_0020, 5'd0);
        regWriteM = 0; memToRegM = 0; memWriteM = 1;
        ALUOutM = 32'h20; writeDataM = 32'h5678; writeRegM = 5'd0;
        #1;
        checks++; if (stallMem !== 1'b1) $display("FAIL rstmid_stall1: got %b want 1", stallMem); else passed++;
        @(posedge clk); #2;
        checks++; if (stallMem !== 1'b1) $display("FAIL rstmid_stall2: got %b want 1", stallMem); else passed++;
        #1 rst = 1;
        #1;
        checks++; if (stallMem !== 1'b0) $display("FAIL rstmid_stall: got %b want 0", stallMem); else passed++;
        checks++;
        if ({regWriteW, memToRegW, writeRegW, readDataW, ALUOutW} !== '0)
            $display("FAIL rstmid_wb: got rw=%b mtr=%b wr=%0d rd=%h alu=%h want all 0",
                     regWriteW, memToRegW, writeRegW, readDataW, ALUOutW);
        else passed++;
        regWriteM = 0; memToRegM = 0; memWriteM = 0; ALUOutM = '0; writeDataM = '0;
        @(posedge clk); #4;
        rst = 0;
        model_reset();
        idle(2);
        do_op(1, 1, 0, 32'h20, 32'h0, 5'd4, seq, n, bok);
        model_commit(1, 1, 0, 32'h20, 32'h0, 5'd4);
        checks++; if (readDataW !== m_rd) $display("FAIL rstmid_keep: got %h want %h", readDataW, m_rd); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq; int n; bit bok;
        do_op(1, 1, 0, 32'h10, 32'h0, 5'd11, seq, n, bok);
        model_commit(1, 1, 0, 32'h10, 32'h0, 5'd11);
        checks++; if (seq !== 8'b011 || n != 3) $display("FAIL b2b_stall1: got seq=%b n=%0d want 011/3", seq, n); else passed++;
        checks++; if (regWriteW !== 1'b1 || readDataW !== m_rd) $display("FAIL b2b_ld1: got rw=%b rd=%h want 1/%h", regWriteW, readDataW, m_rd); else passed++;
        do_op(1, 1, 0, 32'h20, 32'h0, 5'd12, seq, n, bok);
        model_commit(1, 1, 0, 32'h20, 32'h0, 5'd12);
        checks++; if (seq !== 8'b011 || n != 3 || !bok) $display("FAIL b2b_stall2: got seq=%b n=%0d bubble_ok=%0d want 011/3/1", seq, n, bok); else passed++;
        checks++; if (regWriteW !== 1'b1 || writeRegW !== 5'd12 || readDataW !== m_rd) $display("FAIL b2b_ld2: got rw=%b wr=%0d rd=%h want 1/12/%h", regWriteW, writeRegW, readDataW, m_rd); else passed++;
    endtask

    task automatic test_random();
        logic [7:0] seq; int n; bit bok;
        logic rw, mtr, mw; logic [31:0] alu, wd; logic [4:0] wr;
        int kind; bit memop;
        for (int i = 0; i < 48; i++) begin
            kind = int'($urandom_range(0, 2));
            rw = 1'($urandom); wr = 5'($urandom); wd = $urandom;
            alu = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(32, 47)) << 2) | 32'($urandom_range(0, 3));
            case (kind)
                0:       begin mtr = 0; mw = 0; alu = $urandom; end
                1:       begin mtr = 1; mw = 0; rw = 1; end
                default: begin mw = 1; mtr = 1'($urandom); end
            endcase
            memop = mtr | mw;
            do_op(rw, mtr, mw, alu, wd, wr, seq, n, bok);
            model_commit(rw, mtr, mw, alu, wd, wr);
            checks++; if (seq !== exp_seq(memop) || n != exp_cycles(memop)) $display("FAIL rnd%0d_stall: got seq=%b n=%0d want %b/%0d", i, seq, n, exp_seq(memop), exp_cycles(memop)); else passed++;
            checks++; if (!bok) $display("FAIL rnd%0d_bubble: got bubble_ok=0 want 1", i); else passed++;
            checks++; if (regWriteW !== m_rw || memToRegW !== m_mtr || writeRegW !== m_wr) $display("FAIL rnd%0d_ctl: got rw=%b mtr=%b wr=%0d want %b/%b/%0d", i, regWriteW, memToRegW, writeRegW, m_rw, m_mtr, m_wr); else passed++;
            checks++; if (ALUOutW !== m_alu) $display("FAIL rnd%0d_alu: got %h want %h", i, ALUOutW, m_alu); else passed++;
            if (m_rd_valid) begin
                checks++; if (readDataW !== m_rd) $display("FAIL rnd%0d_rd: got %h want %h", i, readDataW, m_rd); else passed++;
            end
            if (!m_mtr || m_rd_valid) begin
                checks++; if (resultW !== (m_mtr ? m_rd : m_alu)) $display("FAIL rnd%0d_result: got %h want %h", i, resultW, m_mtr ? m_rd : m_alu); else passed++;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) begin
            mdl_known[i] = 0;
            mdl_mem[i]   = '0;
        end
        model_reset();
        test_reset();
        test_alu();
        test_store_load();
        test_wrap();
        test_reset_mid_store();
        test_back_to_back();
        test_random();
        idle(2);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 256: data-memory depth in 32-bit words; power of two.
REQ-002 SHALL have parameter MEM_LATENCY, default 3: cycles a load/store occupies the stage; must be at least 1.
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 SHALL list ports as follows.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- regWriteM, memToRegM, memWriteM  input  1 each  controls from the EX/MEM register.
- ALUOutM  input  32  byte address or ALU result.
- writeDataM  input  32  store data.
- writeRegM  input  5  destination register.
- stallMem  output  1  freeze request to the hazard unit (holds PC, IF/ID, ID/EX, EX/MEM).
- regWriteW, memToRegW  output  1 each  MEM/WB control.
- readDataW, ALUOutW  output  32 each  MEM/WB data.
- writeRegW  output  5  MEM/WB destination.
- resultW  output  32  combinational: memToRegW ? readDataW : ALUOutW.

Function
REQ-005 SHALL define a memory op as memToRegM or memWriteM high; all other inputs are non-memory ops.
REQ-006 SHALL pass non-memory ops to MEM/WB at the next edge, 1-cycle latency, with stallMem=0.
REQ-007 SHALL use a 2-state FSM, IDLE and WAIT, plus a wait counter waitCnt.
REQ-008 SHALL drive stallMem = memOp AND (waitCnt != MEM_LATENCY-1); it is combinational and valid in the op's first cycle.
REQ-009 Counter rules:
- waitCnt SHALL increment on each edge where stallMem=1.
- waitCnt SHALL clear to 0 on each edge where stallMem=0.
- FSM SHALL be WAIT iff waitCnt != 0.
REQ-010 SHALL keep each memory op in the stage for exactly MEM_LATENCY cycles, with stallMem high for the first MEM_LATENCY-1.
- MEM_LATENCY=1 means no stall.
REQ-011 SHALL load a bubble into MEM/WB on every edge where stallMem=1: regWriteW=0, memToRegW=0, data fields unchanged.
REQ-012 SHALL commit the store and load MEM/WB only on the completing edge (memOp, stallMem=0); exactly one write per store.
REQ-013 SHALL form the word address as ALUOutM[log2(MEM_WORDS)+1:2].
- Bits [1:0] are ignored.
- Upper bits are ignored, so addresses wrap modulo MEM_WORDS.
REQ-014 SHALL read combinationally and write synchronously; a read and write to the same word on the same edge returns the old data.
REQ-015 SHALL treat memToRegM and memWriteM both high as a store; readDataW gets the pre-write word.
REQ-016 SHALL hold inputs stable while stallMem=1 (upstream contract); behaviour is undefined if they change.

Reset
REQ-017 On rst, SHALL immediately force the following, regardless of clk:
- FSM to IDLE and waitCnt to 0.
- regWriteW, memToRegW, writeRegW, readDataW and ALUOutW to 0.
- stallMem to 0 while rst is high.
REQ-018 SHALL drop an uncommitted store hit by reset mid-operation; memory contents SHALL NOT be cleared by rst.

Structure
REQ-019 SHALL place the IDLE/WAIT encodings and default MEM_WORDS/MEM_LATENCY values in the shared processor package/defines file proc_pkg.
REQ-020 SHALL instantiate one sub-module, data_mem (parameterised depth, sync write, combinational read); FSM, counter and MEM/WB register stay in mem_stage.

Verification
REQ-021 Bench (default parameters) SHALL cover:
- ALU op regWriteM=1, ALUOutM=0x40, writeRegM=5 -> next edge regWriteW=1, ALUOutW=0x40, writeRegW=5, resultW=0x40, stallMem never high.
- Store ALUOutM=0x10, writeDataM=0xDEADBEEF -> stallMem 1,1,0; word 4=0xDEADBEEF after the 3rd edge; regWriteW=0 throughout.
- Then load ALUOutM=0x13, writeRegM=8 -> stallMem 1,1,0; then readDataW=resultW=0xDEADBEEF, regWriteW=1, writeRegW=8.
- Store 0x1234 to 0x410 then load 0x10 -> 0x1234 (wrap).
- Store 0x5678 to 0x20; assert rst during the 2nd stall cycle -> stallMem and all W outputs 0 immediately; later load of 0x20 returns the prior value.
- Two back-to-back loads -> stallMem 1,1,0,1,1,0; two MEM/WB writes, 3 cycles apart.
